check_extrema: RTL and testbench

- DoG extremum detector for the SIFT pipeline.
- Scans two same-size signed DoG layers held in external single-port BRAMs: "first" and "second".
- For every interior pixel, flags whether the first-layer pixel and/or the second-layer pixel is a strict local max or min over its 3x3x2 neighbourhood.
- Feeds keypoint coordinates to the downstream descriptor stage.

---
 rtl/check_extrema.sv | 215 +++++++++++++++++++++
 tb/tb_check_extrema.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/check_extrema.sv
// DoG extremum detector: scans two signed DoG layers held in external 2-cycle-latency
// BRAMs and flags strict 3x3x2 local maxima/minima for every interior pixel.
module check_extrema #(
  parameter int BIT_DEPTH = 9,
  parameter int DIMENSION = 64,
  localparam int AW = $clog2(DIMENSION * DIMENSION),
  localparam int XW = $clog2(DIMENSION)
) (
  input  logic                        clk,
  input  logic                        rst_in,
  input  logic signed [BIT_DEPTH-1:0] first_data,
  output logic        [AW-1:0]        first_address,
  input  logic signed [BIT_DEPTH-1:0] second_data,
  output logic        [AW-1:0]        second_address,
  input  logic                        enable,
  output logic        [XW-1:0]        x,
  output logic        [XW-1:0]        y,
  output logic                        first_is_extremum,
  output logic                        second_is_extremum,
  output logic                        first_is_max,
  output logic                        first_is_min,
  output logic                        second_is_max,
  output logic                        second_is_min,
  output logic                        done_checking,
  output logic        [2:0]           state_number,
  output logic                        read,
  output logic        [XW-1:0]        read_x,
  output logic        [XW-1:0]        read_y
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StWait   = 3'd2,
    StReport = 3'd3,
    StDone   = 3'd4
  } state_t;

  localparam logic [XW-1:0] LastCoord = XW'(DIMENSION - 2);

  state_t                state_q, state_d;
  logic [XW-1:0]         x_q, x_d, y_q, y_d;
  logic [3:0]            k_q, k_d;  // fetch index in StFetch, drain count in StWait
  logic                  clear;

  // Read-return tracking: marks which fetch index is on *_data this cycle.
  logic                  p1_valid_q, p2_valid_q;
  logic [3:0]            p1_k_q, p2_k_q;

  logic signed [BIT_DEPTH-1:0] c1_q, c2_q;
  logic                  c1_max_q, c1_min_q, c2_max_q, c2_min_q;

  logic [XW-1:0]         nx, ny;
  logic [AW-1:0]         addr;

  // State, coordinate and index registers.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic: 9 fetch cycles, 2 drain cycles, 1 report cycle per pixel.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    clear   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (enable) begin
          x_d     = XW'(1);
          y_d     = XW'(1);
          k_d     = '0;
          clear   = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (k_q == 4'd8) begin
          k_d     = '0;
          state_d = StWait;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      StWait: begin
        if (k_q == 4'd1) begin
          k_d     = '0;
          state_d = StReport;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      StReport: begin
        clear = 1'b1;
        if (x_q == LastCoord) begin
          if (y_q == LastCoord) begin
            // Coordinates of the last pixel are left in place while done.
            state_d = StDone;
          end else begin
            x_d     = XW'(1);
            y_d     = y_q + XW'(1);
            state_d = StFetch;
          end
        end else begin
          x_d     = x_q + XW'(1);
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Neighbour address generation: center first, then 8 neighbours in raster order.
  always_comb begin
    nx = x_q;
    ny = y_q;
    unique case (k_q)
      4'd1: begin nx = x_q - XW'(1); ny = y_q - XW'(1); end
      4'd2: begin nx = x_q;          ny = y_q - XW'(1); end
      4'd3: begin nx = x_q + XW'(1); ny = y_q - XW'(1); end
      4'd4: begin nx = x_q - XW'(1); ny = y_q;          end
      4'd5: begin nx = x_q + XW'(1); ny = y_q;          end
      4'd6: begin nx = x_q - XW'(1); ny = y_q + XW'(1); end
      4'd7: begin nx = x_q;          ny = y_q + XW'(1); end
      4'd8: begin nx = x_q + XW'(1); ny = y_q + XW'(1); end
      default: begin nx = x_q; ny = y_q; end
    endcase
    addr = AW'(ny) * AW'(DIMENSION) + AW'(nx);
  end

  assign first_address  = (state_q == StFetch) ? addr : '0;
  assign second_address = (state_q == StFetch) ? addr : '0;

  // Two-stage delay of the fetch index to line up with the BRAM read latency.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      p1_valid_q <= 1'b0;
      p2_valid_q <= 1'b0;
      p1_k_q     <= '0;
      p2_k_q     <= '0;
    end else begin
      p1_valid_q <= (state_q == StFetch);
      p1_k_q     <= k_q;
      p2_valid_q <= p1_valid_q;
      p2_k_q     <= p1_k_q;
    end
  end

  // Comparison accumulators: each flag stays set only while every value seen is strictly beaten.
  always_ff @(posedge clk) begin
    if (rst_in || clear) begin
      c1_q     <= '0;
      c2_q     <= '0;
      c1_max_q <= 1'b0;
      c1_min_q <= 1'b0;
      c2_max_q <= 1'b0;
      c2_min_q <= 1'b0;
    end else if (p2_valid_q) begin
      if (p2_k_q == 4'd0) begin
        // Centers arrive together, so the cross-layer center comparison seeds the flags.
        c1_q     <= first_data;
        c2_q     <= second_data;
        c1_max_q <= first_data > second_data;
        c1_min_q <= first_data < second_data;
        c2_max_q <= second_data > first_data;
        c2_min_q <= second_data < first_data;
      end else begin
        c1_max_q <= c1_max_q & (c1_q > first_data) & (c1_q > second_data);
        c1_min_q <= c1_min_q & (c1_q < first_data) & (c1_q < second_data);
        c2_max_q <= c2_max_q & (c2_q > first_data) & (c2_q > second_data);
        c2_min_q <= c2_min_q & (c2_q < first_data) & (c2_q < second_data);
      end
    end
  end

  // Result outputs are only meaningful (and only nonzero) during the report cycle.
  always_comb begin
    first_is_max       = 1'b0;
    first_is_min       = 1'b0;
    second_is_max      = 1'b0;
    second_is_min      = 1'b0;
    read_x             = '0;
    read_y             = '0;
    if (state_q == StReport) begin
      first_is_max  = c1_max_q;
      first_is_min  = c1_min_q;
      second_is_max = c2_max_q;
      second_is_min = c2_min_q;
    end
    first_is_extremum  = first_is_max | first_is_min;
    second_is_extremum = second_is_max | second_is_min;
    read               = first_is_extremum | second_is_extremum;
    if (read) begin
      read_x = x_q;
      read_y = y_q;
    end
  end

  assign x             = x_q;
  assign y             = y_q;
  assign done_checking = (state_q == StDone);
  assign state_number  = state_q;

endmodule

// File: tb/tb_check_extrema.sv
// Scoreboard bench for check_extrema: directed layer patterns on a 16x16 image,
// expected keypoints queued up front and popped by an independent monitor.
module tb_check_extrema;

  localparam int BD   = 9;
  localparam int DIM  = 16;
  localparam int AW   = $clog2(DIM * DIM);
  localparam int XW   = $clog2(DIM);
  localparam int SCAN = (DIM - 2) * (DIM - 2) * 12;

  logic                 clk = 1'b0;
  logic                 rst_in;
  logic                 enable;
  logic signed [BD-1:0] first_data, second_data;
  logic [AW-1:0]        first_address, second_address;
  logic [XW-1:0]        x, y, read_x, read_y;
  logic                 first_is_extremum, second_is_extremum;
  logic                 first_is_max, first_is_min, second_is_max, second_is_min;
  logic                 done_checking, read;
  logic [2:0]           state_number;

  logic signed [BD-1:0] mem1 [DIM*DIM];
  logic signed [BD-1:0] mem2 [DIM*DIM];
  logic signed [BD-1:0] d1a, d1b;

  // Expected keypoint: coordinates plus {fmax, fmin, smax, smin, fext, sext}.
  typedef struct packed {
    logic [XW-1:0] kx;
    logic [XW-1:0] ky;
    logic [5:0]    flags;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  check_extrema #(.BIT_DEPTH(BD), .DIMENSION(DIM)) dut (
    .clk                (clk),
    .rst_in             (rst_in),
    .first_data         (first_data),
    .first_address      (first_address),
    .second_data        (second_data),
    .second_address     (second_address),
    .enable             (enable),
    .x                  (x),
    .y                  (y),
    .first_is_extremum  (first_is_extremum),
    .second_is_extremum (second_is_extremum),
    .first_is_max       (first_is_max),
    .first_is_min       (first_is_min),
    .second_is_max      (second_is_max),
    .second_is_min      (second_is_min),
    .done_checking      (done_checking),
    .state_number       (state_number),
    .read               (read),
    .read_x             (read_x),
    .read_y             (read_y)
  );

  always #5 clk = ~clk;

  // Two-cycle-latency BRAM models.
  always @(posedge clk) begin
    d1a         <= mem1[first_address];
    first_data  <= d1a;
    d1b         <= mem2[second_address];
    second_data <= d1b;
  end

  // Monitor: pops one expected keypoint for every read strobe.
  always @(negedge clk) begin
    exp_t e, got;
    if (read) begin
      checks++;
      got = '{kx: read_x, ky: read_y,
              flags: {first_is_max, first_is_min, second_is_max, second_is_min,
                      first_is_extremum, second_is_extremum}};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_report got x=%0d y=%0d flags=%b", read_x, read_y, got.flags);
      end else begin
        e = exp_q.pop_front();
        if (got !== e)begin
          errors++;
          $display("FAIL report got x=%0d y=%0d flags=%b exp x=%0d y=%0d flags=%b",
                   got.kx, got.ky, got.flags, e.kx, e.ky, e.flags);
        end
      end
    end
    if (state_number != 3'd3 && !rst_in) begin
      checks++;
      if ({first_is_max, first_is_min, second_is_max, second_is_min, read} !== 5'b0) begin
        errors++;
        $display("FAIL flags_outside_report state=%0d flags=%b", state_number,
                 {first_is_max, first_is_min, second_is_max, second_is_min, read});
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic fill(input int v1, input int v2);
    for (int i = 0; i < DIM * DIM; i++) begin
      mem1[i] = BD'(v1);
      mem2[i] = BD'(v2);
    end
  endtask

  task automatic push(input int px, input int py, input logic [5:0] f);
    exp_q.push_back('{kx: XW'(px), ky: XW'(py), flags: f});
  endtask

  // One full scan: done must rise exactly SCAN cycles after the enable is sampled.
  task automatic run_scan(input string name, input bit busy_pulse);
    @(negedge clk) enable = 1'b1;
    @(negedge clk) enable = 1'b0;
    chk({name, "_fetch_start"}, state_number, 3'd1);
    for (int i = 1; i < SCAN; i++) begin
      @(negedge clk);
      enable = busy_pulse && (i == 40);
    end
    enable = 1'b0;
    chk({name, "_done_early"}, done_checking, 1'b0);
    @(negedge clk);
    chk({name, "_done"}, done_checking, 1'b1);
    chk({name, "_state_done"}, state_number, 3'd4);
    repeat (3) @(negedge clk);
    chk({name, "_done_held"}, done_checking, 1'b1);
    chk({name, "_addr_done"}, first_address, 0);
    chk({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst_in = 1'b1;
    enable = 1'b0;
    fill(0, 0);
    repeat (3) @(negedge clk);
    chk("rst_state", state_number, 3'd0);
    chk("rst_done", done_checking, 1'b0);
    chk("rst_read", read, 1'b0);
    chk("rst_xy", {x, y}, 0);
    chk("rst_addr", {first_address, second_address}, 0);
    rst_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_hold", state_number, 3'd0);

    // All zero: every comparison ties.
    run_scan("zero", 1'b0);

    // Positive spike in first layer; busy enable must be ignored.
    fill(0, 0);
    mem1[12*DIM + 10] = BD'(100);
    push(10, 12, 6'b100010);
    run_scan("spike", 1'b1);

    // Negative spike in second layer.
    fill(0, 0);
    mem2[5*DIM + 5] = BD'(-50);
    push(5, 5, 6'b000101);
    run_scan("min2", 1'b0);

    // Spike on the border is never evaluated.
    fill(0, 0);
    mem1[7*DIM + 0] = BD'(100);
    run_scan("border", 1'b0);

    // Equal neighbouring peaks: strict rule rejects both.
    fill(0, 0);
    mem1[10*DIM + 10] = BD'(50);
    mem1[10*DIM + 11] = BD'(50);
    run_scan("tie", 1'b0);

    // Signed mix: +2 over -1 background, and a second-layer +7 peak.
    fill(-1, -1);
    mem1[3*DIM + 3] = BD'(2);
    mem2[8*DIM + 8] = BD'(7);
    push(3, 3, 6'b100010);
    push(8, 8, 6'b001001);
    run_scan("signed", 1'b0);

    // Reset mid-scan, then a full correct rescan.
    fill(0, 0);
    @(negedge clk) enable = 1'b1;
    @(negedge clk) enable = 1'b0;
    repeat (500) @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    chk("midrst_state", state_number, 3'd0);
    chk("midrst_done", done_checking, 1'b0);
    chk("midrst_addr", first_address, 0);
    chk("midrst_xy", {x, y}, 0);
    rst_in = 1'b0;
    @(negedge clk);
    chk("midrst_idle", state_number, 3'd0);
    mem1[12*DIM + 10] = BD'(100);
    push(10, 12, 6'b100010);
    run_scan("rescan", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
